// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEQ  = 3'd1,
    HOLD = 3'd2,
    GO   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Maximal-length feedback masks (bit i set -> q[i] feeds back)
  localparam logic [3:0] TAPS_W4 = 4'hC;
  localparam logic [6:0] TAPS_W7 = 7'h60;
  localparam logic [7:0] TAPS_W8 = 8'hB8;

  function automatic logic [15:0] default_taps(input int unsigned width);
    case (width)
      4:       return 16'(TAPS_W4);
      8:       return 16'(TAPS_W8);
      default: return 16'(TAPS_W7);
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == SEQ) || (s == HOLD) || (s == GO);
  endfunction

endpackage

// File: rtl/lfsr_n.sv
// Fibonacci-style shift-left LFSR; feedback is the parity of the tapped bits.
module lfsr_n
  import f1_pkg::*;
#(
  parameter int unsigned      WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= SEED;
    end else if (en) begin
      data_out <= {data_out[WIDTH-2:0], ^(data_out & TAPS)};
    end
  end

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: light build-up, random hold, reaction timing and
// jump-start detection, all from one clock with an in-FSM tick divider.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int unsigned           NUM_LIGHTS = 8,
  parameter int unsigned           TICK_DIV   = 16,
  parameter int unsigned           LFSR_WIDTH = 7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = LFSR_WIDTH'(default_taps(LFSR_WIDTH)),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_WIDTH'(1),
  parameter int unsigned           DELAY_MIN  = 2,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  react,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  busy,
  output logic                  time_valid,
  output logic                  jump_start,
  output logic [CNT_W-1:0]      reaction_time,
  output logic [LFSR_WIDTH-1:0] rnd
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = LFSR_WIDTH + 1;

  state_t                  state, next_state;
  logic                    trig_q, react_q;
  logic                    trig_rise, react_rise;
  logic [TW-1:0]           tick_cnt, tick_cnt_n;
  logic [DW-1:0]           delay_cnt, delay_cnt_n;
  logic [CNT_W-1:0]        rt_cnt, rt_cnt_n;
  logic [NUM_LIGHTS-1:0]   lights_n, lights_shift;
  logic                    busy_n, time_valid_n, jump_start_n;
  logic [CNT_W-1:0]        reaction_time_n;
  logic                    tick, seq_full, hold_end;

  lfsr_n #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .data_out (rnd)
  );

  assign trig_rise    = trigger & ~trig_q;
  assign react_rise   = react & ~react_q;
  assign tick         = (tick_cnt == TW'(TICK_DIV - 1));
  assign lights_shift = (lights << 1) | NUM_LIGHTS'(1);
  assign seq_full     = tick && (lights_shift == '1);
  assign hold_end     = tick && (delay_cnt == DW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a react edge beats a simultaneous tick
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (trig_rise) next_state = SEQ;
      SEQ: begin
        if (react_rise)    next_state = DONE;
        else if (seq_full) next_state = HOLD;
      end
      HOLD: begin
        if (react_rise)    next_state = DONE;
        else if (hold_end) next_state = GO;
      end
      GO: if (react_rise) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    lights_n        = lights;
    busy_n          = is_busy(next_state);
    time_valid_n    = time_valid;
    jump_start_n    = jump_start;
    reaction_time_n = reaction_time;
    delay_cnt_n     = delay_cnt;
    rt_cnt_n        = rt_cnt;
    tick_cnt_n      = '0;

    // Divider only runs while staying within SEQ/HOLD; entry into SEQ starts from 0
    if ((state == SEQ || state == HOLD) &&
        (next_state == SEQ || next_state == HOLD) && !tick) begin
      tick_cnt_n = tick_cnt + TW'(1);
    end

    case (state)
      IDLE, DONE: begin
        if (trig_rise) begin
          lights_n        = '0;
          time_valid_n    = 1'b0;
          jump_start_n    = 1'b0;
          reaction_time_n = '0;
        end
      end
      SEQ: begin
        if (react_rise) begin
          lights_n     = '0;
          jump_start_n = 1'b1;
        end else if (tick) begin
          lights_n = lights_shift;
          if (seq_full) delay_cnt_n = DW'(rnd) + DW'(DELAY_MIN);
        end
      end
      HOLD: begin
        if (react_rise) begin
          lights_n     = '0;
          jump_start_n = 1'b1;
        end else if (hold_end) begin
          lights_n = '0;
          rt_cnt_n = '0;
        end else if (tick) begin
          delay_cnt_n = delay_cnt - DW'(1);
        end
      end
      GO: begin
        rt_cnt_n = (rt_cnt == '1) ? rt_cnt : rt_cnt + CNT_W'(1);
        if (react_rise) begin
          reaction_time_n = rt_cnt;
          time_valid_n    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q        <= 1'b0;
      react_q       <= 1'b0;
      tick_cnt      <= '0;
      delay_cnt     <= '0;
      rt_cnt        <= '0;
      lights        <= '0;
      busy          <= 1'b0;
      time_valid    <= 1'b0;
      jump_start    <= 1'b0;
      reaction_time <= '0;
    end else begin
      trig_q        <= trigger;
      react_q       <= react;
      tick_cnt      <= tick_cnt_n;
      delay_cnt     <= delay_cnt_n;
      rt_cnt        <= rt_cnt_n;
      lights        <= lights_n;
      busy          <= busy_n;
      time_valid    <= time_valid_n;
      jump_start    <= jump_start_n;
      reaction_time <= reaction_time_n;
    end
  end

endmodule
